// File: rtl/cpu_bus_dma.sv
// cpu_bus_dma: single-channel memory-to-memory DMA that borrows the CPU bus.
// It requests the bus with busrq_n, waits for busak_n, then moves one byte per
// RD1/RD2/WR1/WR2 sequence until the count runs out or an abort/protocol error
// ends the transfer. It then releases the bus through a one-cycle REL state.
//
// Optional feature: define DMA_FILL_EN to enable fill mode. In fill mode the
// read cycles are skipped, fill_val is written to every destination address,
// and the source address does not advance. When the macro is undefined, fill
// and fill_val are ignored.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             one-cycle transfer request (honoured only in IDLE)
//   src, dst, len     source/destination start addresses and byte count
//   fill, fill_val    fill-mode select and fill byte
//   abort             early-termination request
//   busrq_n, busak_n  CPU bus request/acknowledge handshake
//   bus_en            DMA owns A/dout/strobes
//   A, dout, di       address, write data, read data (one-cycle read latency)
//   mreq_n/rd_n/wr_n  active-low memory strobes
//   busy, done, aborted, remaining  status
module cpu_bus_dma #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      src,
  input  logic [15:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic             fill,
  input  logic [7:0]       fill_val,
  input  logic             abort,
  output logic             busrq_n,
  input  logic             busak_n,
  output logic             bus_en,
  output logic [15:0]      A,
  output logic [7:0]       dout,
  input  logic [7:0]       di,
  output logic             mreq_n,
  output logic             rd_n,
  output logic             wr_n,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] remaining
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StRd1  = 3'd2;
  localparam logic [2:0] StRd2  = 3'd3;
  localparam logic [2:0] StWr1  = 3'd4;
  localparam logic [2:0] StWr2  = 3'd5;
  localparam logic [2:0] StRel  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [15:0]      src_q, src_d;
  logic [15:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       data_q, data_d;
  logic             abort_pend_q, abort_pend_d;
  logic             err_q, err_d;
  logic             zero_done_q, zero_done_d;

  logic             accept;
  logic             in_bus;
  logic             fill_mode;
  logic [7:0]       fill_byte;

  assign accept = (state_q == StIdle) && start && (len != '0);
  assign in_bus = (state_q == StRd1) || (state_q == StRd2) ||
                  (state_q == StWr1) || (state_q == StWr2);

`ifdef DMA_FILL_EN
  logic       fill_q, fill_d;
  logic [7:0] fill_val_q, fill_val_d;

  always_comb begin
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
    if (accept) begin
      fill_d     = fill;
      fill_val_d = fill_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q     <= 1'b0;
      fill_val_q <= 8'h00;
    end else begin
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
    end
  end

  assign fill_mode = fill_q;
  assign fill_byte = fill_val_q;
`else
  logic unused_fill;
  assign unused_fill = ^{fill, fill_val};
  assign fill_mode   = 1'b0;
  assign fill_byte   = 8'h00;
`endif

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    data_d       = data_q;
    abort_pend_d = abort_pend_q;
    err_d        = err_q;
    zero_done_d  = 1'b0;

    // Abort and lost-grant are remembered so the byte in flight still completes.
    if (in_bus) begin
      if (abort)   abort_pend_d = 1'b1;
      if (busak_n) err_d        = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          src_d        = src;
          dst_d        = dst;
          rem_d        = len;
          abort_pend_d = 1'b0;
          err_d        = 1'b0;
          state_d      = StReq;
        end else if (start) begin
          zero_done_d = 1'b1;
        end
      end
      StReq: begin
        if (abort) begin
          state_d = StRel;
        end else if (!busak_n) begin
          state_d = fill_mode ? StWr1 : StRd1;
        end
      end
      StRd1: state_d = StRd2;
      StRd2: begin
        data_d  = di;
        state_d = StWr1;
      end
      StWr1: state_d = StWr2;
      StWr2: begin
        src_d = fill_mode ? src_q : src_q + 16'd1;
        dst_d = dst_q + 16'd1;
        rem_d = rem_q - LEN_W'(1);
        // Include this cycle's abort/busak_n since the flags update only at the edge.
        if ((rem_q == LEN_W'(1)) || abort_pend_q || abort || busak_n || err_q) begin
          state_d = StRel;
        end else begin
          state_d = fill_mode ? StWr1 : StRd1;
        end
      end
      StRel:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      src_q        <= 16'h0000;
      dst_q        <= 16'h0000;
      rem_q        <= '0;
      data_q       <= 8'h00;
      abort_pend_q <= 1'b0;
      err_q        <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      data_q       <= data_d;
      abort_pend_q <= abort_pend_d;
      err_q        <= err_d;
      zero_done_q  <= zero_done_d;
    end
  end

  always_comb begin
    busrq_n = 1'b1;
    bus_en  = 1'b0;
    A       = 16'h0000;
    dout    = 8'h00;
    mreq_n  = 1'b1;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    case (state_q)
      StReq: busrq_n = 1'b0;
      StRd1, StRd2: begin
        busrq_n = 1'b0;
        bus_en  = 1'b1;
        A       = src_q;
        mreq_n  = 1'b0;
        rd_n    = 1'b0;
      end
      StWr1, StWr2: begin
        busrq_n = 1'b0;
        bus_en  = 1'b1;
        A       = dst_q;
        dout    = fill_mode ? fill_byte : data_q;
        mreq_n  = 1'b0;
        wr_n    = (state_q == StWr2) ? 1'b0 : 1'b1;
      end
      default: ;
    endcase
  end

  // A lost grant always reports as aborted, even if it hit the last byte.
  assign busy      = (state_q != StIdle);
  assign done      = zero_done_q || ((state_q == StRel) && (rem_q == '0) && !err_q);
  assign aborted   = (state_q == StRel) && ((rem_q != '0) || err_q);
  assign remaining = rem_q;

endmodule

// File: tb/tb_cpu_bus_dma.sv
module tb_cpu_bus_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] len;
  logic        fill;
  logic [7:0]  fill_val;
  logic        abort;
  logic        busrq_n;
  logic        busak_n;
  logic        bus_en;
  logic [15:0] A;
  logic [7:0]  dout;
  logic [7:0]  di = 8'h00;
  logic        mreq_n;
  logic        rd_n;
  logic        wr_n;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] remaining;

  int total = 0;
  int bad   = 0;

  // Read-side memory is loaded by the stimulus; write-side memory records DMA writes.
  logic [7:0] rmem [65536];
  logic [7:0] wmem [65536];

  int done_cnt = 0;
  int abrt_cnt = 0;
  int mreq_cnt = 0;
  int rd_cnt   = 0;
  int rq_cnt   = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  cpu_bus_dma #(.LEN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill      (fill),
    .fill_val  (fill_val),
    .abort     (abort),
    .busrq_n   (busrq_n),
    .busak_n   (busak_n),
    .bus_en    (bus_en),
    .A         (A),
    .dout      (dout),
    .di        (di),
    .mreq_n    (mreq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .remaining (remaining)
  );

  // Memory: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (!mreq_n && !rd_n) di <= rmem[A];
    if (bus_en && !mreq_n && !wr_n) begin
      wmem[A] <= dout;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (done)             done_cnt <= done_cnt + 1;
    if (aborted)          abrt_cnt <= abrt_cnt + 1;
    if (!mreq_n)          mreq_cnt <= mreq_cnt + 1;
    if (!rd_n)            rd_cnt   <= rd_cnt + 1;
    if (!busrq_n)         rq_cnt   <= rq_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int n;
  int d0, a0, m0, r0, q0, w0;

  task automatic snap();
    d0 = done_cnt; a0 = abrt_cnt; m0 = mreq_cnt; r0 = rd_cnt; q0 = rq_cnt; w0 = wr_cnt;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rmem[i] = 8'h00;
    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    fill = 1'b0; fill_val = 8'h00; abort = 1'b0; busak_n = 1'b1;

    // Reset state
    step(); step();
    chk("rst_busrq_n", busrq_n, 1);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_mreq_n", mreq_n, 1);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_A", A, 16'h0000);
    chk("rst_dout", dout, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_remaining", remaining, 0);
    reset = 1'b0;
    step();

    // Copy 3 bytes, grant arrives 2 cycles after the request
    rmem[16'h03C0] = 8'h84; rmem[16'h03C1] = 8'h11; rmem[16'h03C2] = 8'h22;
    snap();
    src = 16'h03C0; dst = 16'h8000; len = 16'd3; start = 1'b1;
    step(); start = 1'b0;
    chk("copy_req_busy", busy, 1);
    chk("copy_req_busrq", busrq_n, 0);
    chk("copy_req_bus_en", bus_en, 0);
    step(); step(); busak_n = 1'b0;
    step();
    chk("copy_rd1_bus_en", bus_en, 1);
    chk("copy_rd1_A", A, 16'h03C0);
    chk("copy_rd1_rd_n", rd_n, 0);
    chk("copy_rd1_wr_n", wr_n, 1);
    n = 0;
    while (busrq_n === 1'b0 && n < 40) begin
      step(); n++;
      if (n == 2) begin
        chk("copy_wr1_A", A, 16'h8000);
        chk("copy_wr1_dout", dout, 8'h84);
        chk("copy_wr1_wr_n", wr_n, 1);
      end
      if (n == 3) chk("copy_wr2_wr_n", wr_n, 0);
    end
    // 12 edges after the one entering RD1: 3 bytes x 4 cycles, then REL
    chk("copy_busrq_rise", n, 12);
    chk("copy_rel_done", done, 1);
    busak_n = 1'b1;
    step();
    chk("copy_idle_busy", busy, 0);
    chk("copy_done_once", done_cnt - d0, 1);
    chk("copy_mem0", wmem[16'h8000], 8'h84);
    chk("copy_mem1", wmem[16'h8001], 8'h11);
    chk("copy_mem2", wmem[16'h8002], 8'h22);
    chk("copy_remaining", remaining, 0);

    // Source address wrap
    rmem[16'hFFFF] = 8'h5A; rmem[16'h0000] = 8'hA5;
    src = 16'hFFFF; dst = 16'h1000; len = 16'd2; busak_n = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step();
    chk("wrap_A0", A, 16'hFFFF);
    chk("wrap_rem2", remaining, 2);
    step(); step(); step(); step();
    chk("wrap_A1", A, 16'h0000);
    chk("wrap_rem1", remaining, 1);
    step(); step(); step(); step();
    chk("wrap_rem0", remaining, 0);
    chk("wrap_done", done, 1);
    busak_n = 1'b1;
    step();
    chk("wrap_mem0", wmem[16'h1000], 8'h5A);
    chk("wrap_mem1", wmem[16'h1001], 8'hA5);

    // Zero-length start
    snap();
    len = 16'd0; start = 1'b1;
    step(); start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_busrq", busrq_n, 1);
    step();
    chk("zero_done_drop", done, 0);
    chk("zero_no_busrq", rq_cnt - q0, 0);
    chk("zero_done_once", done_cnt - d0, 1);

    // Abort during 2nd byte's RD2
    for (int i = 0; i < 5; i++) rmem[16'h0100 + i] = 8'(i + 1);
    snap();
    src = 16'h0100; dst = 16'h0200; len = 16'd5; busak_n = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step(); step(); step(); step();
    abort = 1'b1;
    step(); abort = 1'b0;
    step(); step();
    chk("abort_pulse", aborted, 1);
    chk("abort_no_done", done, 0);
    chk("abort_rem", remaining, 3);
    busak_n = 1'b1;
    step();
    chk("abort_idle", busy, 0);
    chk("abort_rem_idle", remaining, 3);
    chk("abort_wr_count", wr_cnt - w0, 2);
    chk("abort_mem0", wmem[16'h0200], 8'h01);
    chk("abort_mem1", wmem[16'h0201], 8'h02);
    chk("abort_done_cnt", done_cnt - d0, 0);
    chk("abort_abrt_cnt", abrt_cnt - a0, 1);

    // Grant never given; a start while busy is ignored; abort from REQ
    snap();
    src = 16'h0300; dst = 16'h0400; len = 16'd4; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    len = 16'd0; start = 1'b1;
    step(); start = 1'b0;
    chk("nogrant_busy", busy, 1);
    chk("nogrant_busrq", busrq_n, 0);
    chk("nogrant_start_ign", done, 0);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("nogrant_aborted", aborted, 1);
    chk("nogrant_rel_busrq", busrq_n, 1);
    chk("nogrant_rel_bus_en", bus_en, 0);
    step();
    chk("nogrant_idle", busy, 0);
    chk("nogrant_no_mreq", mreq_cnt - m0, 0);
    chk("nogrant_abrt_cnt", abrt_cnt - a0, 1);

    // Grant lost during first byte's RD2
    snap();
    src = 16'h0100; dst = 16'h0300; len = 16'd3; busak_n = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    busak_n = 1'b1;
    step(); step(); step();
    chk("perr_aborted", aborted, 1);
    chk("perr_done", done, 0);
    chk("perr_rem", remaining, 2);
    step();
    chk("perr_idle", busy, 0);
    chk("perr_wr_count", wr_cnt - w0, 1);

    // Reset in the middle of a transfer
    src = 16'h0100; dst = 16'h0500; len = 16'd3; busak_n = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step();
    chk("mrst_bus_en_before", bus_en, 1);
    snap();
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("mrst_bus_en", bus_en, 0);
    chk("mrst_busrq", busrq_n, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_rem", remaining, 0);
    busak_n = 1'b1;
    step(); step();
    chk("mrst_no_done", done_cnt - d0, 0);
    chk("mrst_no_abort", abrt_cnt - a0, 0);

`ifdef DMA_FILL_EN
    // Fill mode: 2 cycles per byte, no reads
    snap();
    fill = 1'b1; fill_val = 8'hC2; src = 16'h0100; dst = 16'h2000; len = 16'd4;
    busak_n = 1'b0; start = 1'b1;
    step(); start = 1'b0; fill = 1'b0;
    step();
    chk("fill_wr1_A", A, 16'h2000);
    n = 0;
    while (busrq_n === 1'b0 && n < 40) begin
      step(); n++;
    end
    chk("fill_cycles", n, 8);
    chk("fill_done", done, 1);
    busak_n = 1'b1;
    step();
    chk("fill_no_rd", rd_cnt - r0, 0);
    for (int i = 0; i < 4; i++) chk("fill_mem", wmem[16'h2000 + i], 8'hC2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
